// File: rtl/img_pkg.sv
// Shared image types for the 3x3 window former and the kernels fed by it.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: default geometry, tap index constants (k = 3*y + x, y=0 top,
// x=0 left/oldest), pixel and window types, and window flag struct.
package img_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int WIDTH_DEF      = 1920;
  localparam int HEIGHT_DEF     = 1080;
  localparam int COL_BITS_DEF   = 11;
  localparam int ROW_BITS_DEF   = 11;

  localparam int TAP_ROWS = 3;
  localparam int TAP_COLS = 3;
  localparam int NUM_TAPS = TAP_ROWS * TAP_COLS;

  // Named taps so kernels do not hard-code k = 3*y + x.
  localparam int TAP_TL = 0;
  localparam int TAP_TC = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MC = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BC = 7;
  localparam int TAP_BR = 8;

  typedef logic [DATA_WIDTH_DEF-1:0] pixel_t;

  // Packed so element k lands at [k*DATA_WIDTH +: DATA_WIDTH] of the flat bus.
  typedef pixel_t [NUM_TAPS-1:0] win_arr_t;

  typedef struct packed {
    logic sol;
    logic eol;
    logic sof;
    logic eof;
  } win_flags_t;

  function automatic int tap_idx(input int y, input int x);
    return TAP_COLS * y + x;
  endfunction

endpackage

// File: rtl/window_3x3_if.sv
// Stream interfaces around the 3x3 window former.
// Latency: n/a (wiring only).
// Backpressure: none; both streams are valid-only.
//
// pix3_if: three column-aligned rows (top = r-2, mid = r-1, bot = r) + valid/sof.
// win_if : flat 9-tap window + valid and line/frame position flags.
interface pix3_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] row_top;
  logic [DATA_WIDTH-1:0] row_mid;
  logic [DATA_WIDTH-1:0] row_bot;
  logic                  in_valid;
  logic                  in_sof;

  modport master (output row_top, row_mid, row_bot, in_valid, in_sof);
  modport slave  (input  row_top, row_mid, row_bot, in_valid, in_sof);
endinterface

interface win_if
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = 16
);
  logic [NUM_TAPS*DATA_WIDTH-1:0] win;
  logic                           out_valid;
  logic                           out_sol;
  logic                           out_eol;
  logic                           out_sof;
  logic                           out_eof;

  modport master (output win, out_valid, out_sol, out_eol, out_sof, out_eof);
  modport slave  (input  win, out_valid, out_sol, out_eol, out_sof, out_eof);
endinterface

// File: rtl/win_col_shift.sv
// 3-deep column shift register for one window row; advances only when enabled.
// Latency: 1 clk from an enabled beat to the new value appearing on taps_o[2].
// Backpressure: none; en_i gates movement, idle cycles hold the contents.
//
// Ports: clk, rst (sync, active-high), en_i, d_i (incoming pixel),
//        taps_o[x] with x=0 oldest/left and x=2 newest.
module win_col_shift #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_i,
  input  logic [DATA_WIDTH-1:0]      d_i,
  output logic [2:0][DATA_WIDTH-1:0] taps_o
);

  logic [2:0][DATA_WIDTH-1:0] taps_q;
  logic [2:0][DATA_WIDTH-1:0] taps_d;

  always_comb begin
    taps_d = taps_q;
    if (en_i) begin
      taps_d[0] = taps_q[1];
      taps_d[1] = taps_q[2];
      taps_d[2] = d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      taps_q <= '0;
    end else begin
      taps_q <= taps_d;
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/window_3x3.sv
// Builds a 3x3 neighbourhood from three line-aligned pixel streams; border pixels dropped.
// Latency: exactly 1 clk from the accepted interior beat to out_valid/win.
// Backpressure: none; every out_valid beat must be consumed downstream.
//
// Ports: clk, rst (sync, active-high), pix_i (pix3_if.slave: row_top/mid/bot,
//        in_valid, in_sof), win_o (win_if.master: win, out_valid, out_sol,
//        out_eol, out_sof, out_eof). Output image is (WIDTH-2)x(HEIGHT-2).
module window_3x3
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int WIDTH      = WIDTH_DEF,
  parameter int HEIGHT     = HEIGHT_DEF,
  parameter int COL_BITS   = COL_BITS_DEF,
  parameter int ROW_BITS   = ROW_BITS_DEF
) (
  input  logic   clk,
  input  logic   rst,
  pix3_if.slave  pix_i,
  win_if.master  win_o
);

  localparam logic [COL_BITS-1:0] COL_LAST  = COL_BITS'(WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(HEIGHT - 1);
  localparam logic [COL_BITS-1:0] COL_WIN0  = COL_BITS'(2);
  localparam logic [ROW_BITS-1:0] ROW_WIN0  = ROW_BITS'(2);

  // Row inputs indexed by window y (0 = top = oldest line).
  logic [2:0][DATA_WIDTH-1:0]      row_in;
  logic [2:0][2:0][DATA_WIDTH-1:0] taps;

  assign row_in[0] = pix_i.row_top;
  assign row_in[1] = pix_i.row_mid;
  assign row_in[2] = pix_i.row_bot;

  for (genvar y = 0; y < TAP_ROWS; y++) begin : g_row
    win_col_shift #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
      .clk    (clk),
      .rst    (rst),
      .en_i   (pix_i.in_valid),
      .d_i    (row_in[y]),
      .taps_o (taps[y])
    );
  end

  logic [COL_BITS-1:0] col_q, col_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic                vld_q, vld_d;
  win_flags_t          flags_q, flags_d;
  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] win_q, win_d;

  // An sof beat is position (0,0) whatever the counters say.
  logic [COL_BITS-1:0] col_eff;
  logic [ROW_BITS-1:0] row_eff;
  logic                at_col_last;
  logic                at_row_last;
  logic                interior;

  assign col_eff     = pix_i.in_sof ? '0 : col_q;
  assign row_eff     = pix_i.in_sof ? '0 : row_q;
  assign at_col_last = (col_eff == COL_LAST);
  assign at_row_last = (row_eff == ROW_LAST);
  // Beats at col 0/1 or row 0/1 still shift taps but never complete a window,
  // which also keeps windows from straddling lines or frames.
  assign interior    = (col_eff >= COL_WIN0) && (row_eff >= ROW_WIN0);

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    vld_d   = 1'b0;
    flags_d = '0;
    win_d   = win_q;
    if (pix_i.in_valid) begin
      if (at_col_last) begin
        col_d = '0;
        row_d = at_row_last ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
      if (interior) begin
        vld_d       = 1'b1;
        flags_d.sol = (col_eff == COL_WIN0);
        flags_d.eol = at_col_last;
        flags_d.sof = (row_eff == ROW_WIN0) && (col_eff == COL_WIN0);
        flags_d.eof = at_row_last && at_col_last;
        // Window as it will stand after this beat's shift: the two newest
        // stored columns become x=0/1 and the incoming pixel is x=2.
        for (int y = 0; y < TAP_ROWS; y++) begin
          win_d[tap_idx(y, 0)] = taps[y][1];
          win_d[tap_idx(y, 1)] = taps[y][2];
          win_d[tap_idx(y, 2)] = row_in[y];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      vld_q   <= 1'b0;
      flags_q <= '0;
      win_q   <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      vld_q   <= vld_d;
      flags_q <= flags_d;
      win_q   <= win_d;
    end
  end

  assign win_o.win       = win_q;
  assign win_o.out_valid = vld_q;
  assign win_o.out_sol   = flags_q.sol;
  assign win_o.out_eol   = flags_q.eol;
  assign win_o.out_sof   = flags_q.sof;
  assign win_o.out_eof   = flags_q.eof;

endmodule

// File: tb/tb_window_3x3.sv
// Self-checking bench for window_3x3 at WIDTH=5, HEIGHT=4, pixel = frame<<8 | row<<4 | col.
// Expected windows are pushed to a scoreboard when a beat is driven and popped when out_valid shows.
// Scenario table covers continuous, gapped, back-to-back and resync frames; reset/idle are hand-written.
module tb_window_3x3;
  import img_pkg::*;

  localparam int DW = 16;
  localparam int W  = 5;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pix3_if #(.DATA_WIDTH(DW)) pin  ();
  win_if  #(.DATA_WIDTH(DW)) wout ();

  window_3x3 #(
    .DATA_WIDTH (DW),
    .WIDTH      (W),
    .HEIGHT     (H),
    .COL_BITS   (3),
    .ROW_BITS   (2)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .pix_i (pin.slave),
    .win_o (wout.master)
  );

  typedef struct {
    logic [9*DW-1:0] win;
    logic            sol;
    logic            eol;
    logic            sof;
    logic            eof;
    int              cyc;
  } exp_t;

  typedef struct {
    int gap_max;
    int n_beats;
    int abort_at;
    int exp_windows;
  } scen_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   popped      = 0;
  int   mf = 0, mr = 0, mc = 0;
  logic [9*DW-1:0] sof_win_seen = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pix(input int f, input int r, input int c);
    int ff = f;
    int rr = r;
    if (rr < 0) begin
      rr += H;
      ff -= 1;
    end
    return DW'(((ff & 15) << 8) | (rr << 4) | c);
  endfunction

  task automatic chk(input string name, input logic [9*DW-1:0] got, input logic [9*DW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Drive one beat at a negedge; the DUT captures it at the next posedge.
  task automatic beat(input bit sof);
    exp_t e;
    if (sof) begin
      if (mr != 0 || mc != 0) mf++;
      mr = 0;
      mc = 0;
    end
    pin.row_top  = pix(mf, mr - 2, mc);
    pin.row_mid  = pix(mf, mr - 1, mc);
    pin.row_bot  = pix(mf, mr, mc);
    pin.in_valid = 1'b1;
    pin.in_sof   = sof;
    if (mr >= 2 && mc >= 2) begin
      e.win = '0;
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 3; x++)
          e.win[(3*y + x)*DW +: DW] = pix(mf, mr - 2 + y, mc - 2 + x);
      e.sol = (mc == 2);
      e.eol = (mc == W - 1);
      e.sof = (mr == 2) && (mc == 2);
      e.eof = (mr == H - 1) && (mc == W - 1);
      e.cyc = cyc + 1;
      q.push_back(e);
    end
    @(negedge clk);
    pin.in_valid = 1'b0;
    pin.in_sof   = 1'b0;
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) begin
        mr = 0;
        mf++;
      end
    end
  endtask

  // Scoreboard monitor, sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      bit   exp_now;
      exp_t e;
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_window: expected at cyc %0d, still absent at cyc %0d", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      exp_now = (q.size() > 0) && (q[0].cyc == cyc);
      if (wout.out_valid === 1'b1 || exp_now) begin
        vectors++;
        if (wout.out_valid !== exp_now) begin
          miscompares++;
          $display("FAIL out_valid cyc %0d: got %b expected %b", cyc, wout.out_valid, exp_now);
        end else begin
          e = q.pop_front();
          popped++;
          if (wout.out_sof) sof_win_seen = wout.win;
          if (wout.win !== e.win || wout.out_sol !== e.sol || wout.out_eol !== e.eol ||
              wout.out_sof !== e.sof || wout.out_eof !== e.eof) begin
            miscompares++;
            $display("FAIL window cyc %0d: got win=%h sol/eol/sof/eof=%b%b%b%b expected win=%h %b%b%b%b",
                     cyc, wout.win, wout.out_sol, wout.out_eol, wout.out_sof, wout.out_eof,
                     e.win, e.sol, e.eol, e.sof, e.eof);
          end
        end
      end
    end
  end

  initial begin
    scen_t           scen[4];
    logic [9*DW-1:0] first_win_ref;
    int              p0;

    // {gap_max, beats, sof-resync beat index (-1 none), windows expected}
    scen[0] = '{0, 20, -1, 6};   // one continuous frame
    scen[1] = '{3, 20, -1, 6};   // same frame with random idle gaps
    scen[2] = '{0, 40, -1, 12};  // two back-to-back frames, second via row wrap
    scen[3] = '{0, 33, 13, 7};   // resync at (2,3): 1 window from old frame, 6 from new

    first_win_ref = '0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        first_win_ref[(3*y + x)*DW +: DW] = DW'((y << 4) | x);

    rst          = 1'b1;
    pin.row_top  = '0;
    pin.row_mid  = '0;
    pin.row_bot  = '0;
    pin.in_valid = 1'b0;
    pin.in_sof   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("reset_out_valid", 144'(wout.out_valid), '0);
    chk("reset_win", wout.win, '0);
    chk("reset_flags", 144'({wout.out_sol, wout.out_eol, wout.out_sof, wout.out_eof}), '0);

    // Long idle after reset; the monitor flags any out_valid. A frame with no
    // sof afterwards only lines up if the counters are still at (0,0).
    repeat (100) @(negedge clk);
    mf = 0; mr = 0; mc = 0;
    p0 = popped;
    for (int b = 0; b < W*H; b++) beat(1'b0);
    repeat (3) @(negedge clk);
    chk("idle_then_nosof_windows", 144'(popped - p0), 144'(6));

    for (int s = 0; s < 4; s++) begin
      if (s == 0) mf = 0;
      p0 = popped;
      for (int b = 0; b < scen[s].n_beats; b++) begin
        beat((b == 0) || (b == scen[s].abort_at));
        if (scen[s].gap_max > 0) repeat ($urandom_range(0, scen[s].gap_max)) @(negedge clk);
      end
      repeat (3) @(negedge clk);
      chk($sformatf("scen%0d_window_count", s), 144'(popped - p0), 144'(scen[s].exp_windows));
      chk($sformatf("scen%0d_queue_drained", s), 144'(q.size()), '0);
      if (s == 0) chk("first_window_pixels", sof_win_seen, first_win_ref);
    end

    // Reset mid-line while out_valid is high, then replay the first frame.
    mf = 0;
    for (int b = 0; b < 2*W + 4; b++) beat(b == 0);
    chk("pre_reset_out_valid", 144'(wout.out_valid), 144'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("post_reset_out_valid", 144'(wout.out_valid), '0);
    chk("post_reset_win", wout.win, '0);
    chk("post_reset_flags", 144'({wout.out_sol, wout.out_eol, wout.out_sof, wout.out_eof}), '0);
    mf = 0; mr = 0; mc = 0;
    sof_win_seen = '0;
    p0 = popped;
    for (int b = 0; b < W*H; b++) beat(b == 0);
    repeat (3) @(negedge clk);
    chk("restart_window_count", 144'(popped - p0), 144'(6));
    chk("restart_first_window", sof_win_seen, first_win_ref);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
